bfs_lane_param: RTL and testbench

Parametrised edge-centric BFS processing lane, the successor to the fixed 4-stage BFS pipeline. It owns the level memory for one vertex partition and accepts 512-bit-class edge/update words over a ready/valid handshake. It serialises the slots of each word, performs scatter (emit destinations of frontier edges) or gather (mark unvisited vertices), and buffers emitted updates in an output FIFO with back-pressure. Several lanes sit side by side under the BFS top level, one per partition.

---
 rtl/bfs_lane_param.sv | 198 +++++++++++++++++++
 tb/tb_bfs_lane_param.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfs_lane_param.sv
// Edge-centric BFS lane: owns one partition's level memory, serialises slot words through a
// two-stage read/compare pipe and buffers scatter updates in an output FIFO.
module bfs_lane_param #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned SLOTS        = 8,
  parameter int unsigned PARTITION_ID = 0,
  parameter int unsigned LEVEL_W      = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [LEVEL_W-1:0]  current_level,
  input  logic [31:0]         root_vertex,
  input  logic [64*SLOTS-1:0] in_word,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [31:0]         out_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         update_count,
  output logic [31:0]         visit_count,
  output logic                done
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned WORD_W = 64 * SLOTS;
  localparam int unsigned SlotW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);
  localparam int unsigned HiW    = 32 - ADDR_W;
  localparam logic [HiW-1:0]     PartId    = HiW'(PARTITION_ID);
  localparam logic [LEVEL_W-1:0] Unvisited = '1;
  localparam logic [ADDR_W:0]    InitEnd   = (ADDR_W+1)'(DEPTH);
  localparam logic [FifoAw:0]    FifoFull  = (FifoAw+1)'(FIFO_DEPTH);
  localparam logic [1:0] ModeScatter = 2'd1;
  localparam logic [1:0] ModeGather  = 2'd2;
  localparam logic [1:0] ModeInit    = 2'd3;

  typedef enum logic [1:0] {StIdle, StInit, StProc, StDrain} state_e;
  state_e state_q, state_d;

  logic [ADDR_W:0]    init_ptr_q;
  logic [WORD_W-1:0]  word_q;
  logic [1:0]         mode_q;
  logic               last_q;
  logic [SlotW-1:0]   slot_q;
  logic               s1_valid_q, s1_gather_q;
  logic [ADDR_W-1:0]  s1_addr_q;
  logic [31:0]        s1_dst_q;
  logic [LEVEL_W-1:0] s1_level_q;
  logic [LEVEL_W-1:0] level_mem [DEPTH];
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [FifoAw-1:0]  fifo_wr_q, fifo_rd_q;
  logic [FifoAw:0]    fifo_cnt_q, occ;
  logic [31:0]        upd_cnt_q, vis_cnt_q;

  logic [63:0]        cur_slot;
  logic [31:0]        src;
  logic               slot_act, stall, issue, accept, drained, push, pop, hit_gather;
  logic [LEVEL_W-1:0] next_level, rd_level;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_wa;
  logic [LEVEL_W-1:0] mem_wd;

  always_comb begin
    cur_slot = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (slot_q == SlotW'(k)) cur_slot = word_q[64*k +: 64];
    end
  end

  assign src        = cur_slot[31:0];
  assign slot_act   = (src != 32'hFFFF_FFFF) && (src[31:ADDR_W] == PartId);
  assign occ        = fifo_cnt_q + {{FifoAw{1'b0}}, s1_valid_q};
  assign stall      = occ >= FifoFull;
  assign accept     = in_valid && in_ready;
  assign drained    = !s1_valid_q && (fifo_cnt_q == '0);
  assign next_level = current_level + LEVEL_W'(1);
  assign push       = s1_valid_q && !s1_gather_q && (s1_level_q == current_level);
  assign hit_gather = s1_valid_q && s1_gather_q && (s1_level_q == Unvisited);
  assign out_valid  = fifo_cnt_q != '0;
  assign pop        = out_valid && out_ready;
  assign out_word   = out_valid ? fifo_mem[fifo_rd_q] : '0;
  assign update_count = upd_cnt_q;
  assign visit_count  = vis_cnt_q;

  // A gather mark in the compare stage must be seen by a read of the same vertex this cycle.
  assign rd_level = (hit_gather && (s1_addr_q == src[ADDR_W-1:0])) ? next_level
                                                                   : level_mem[src[ADDR_W-1:0]];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mode == ModeInit) state_d = StInit;
        else if (accept)      state_d = StProc;
      end
      StInit:  if (init_ptr_q == InitEnd) state_d = StIdle;
      StProc:  if (issue && slot_q == SlotW'(SLOTS - 1)) state_d = last_q ? StDrain : StIdle;
      StDrain: if (drained) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    issue    = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = (mode == ModeScatter) || (mode == ModeGather);
      StInit:  done = (init_ptr_q == InitEnd);
      StProc:  issue = !stall;
      StDrain: done = drained;
      default: ;
    endcase
    if (rst) begin
      in_ready = 1'b0;
      done     = 1'b0;
      issue    = 1'b0;
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = s1_addr_q;
    mem_wd = next_level;
    if (state_q == StInit) begin
      if (init_ptr_q != InitEnd) begin
        mem_we = 1'b1;
        mem_wa = init_ptr_q[ADDR_W-1:0];
        mem_wd = Unvisited;
      end else if (root_vertex[31:ADDR_W] == PartId) begin
        mem_we = 1'b1;
        mem_wa = root_vertex[ADDR_W-1:0];
        mem_wd = '0;
      end
    end else if (hit_gather) begin
      mem_we = 1'b1;
    end
    if (rst) mem_we = 1'b0;
  end

  // Storage arrays carry no reset; the level memory is only valid after INIT.
  always_ff @(posedge clk) begin
    if (mem_we) level_mem[mem_wa] <= mem_wd;
    if (push)   fifo_mem[fifo_wr_q] <= s1_dst_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      init_ptr_q  <= '0;
      word_q      <= '0;
      mode_q      <= '0;
      last_q      <= 1'b0;
      slot_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_gather_q <= 1'b0;
      s1_addr_q   <= '0;
      s1_dst_q    <= '0;
      s1_level_q  <= '0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      fifo_cnt_q  <= '0;
      upd_cnt_q   <= '0;
      vis_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && mode == ModeInit) begin
        init_ptr_q <= '0;
        upd_cnt_q  <= '0;
        vis_cnt_q  <= '0;
      end else begin
        if (state_q == StInit) init_ptr_q <= init_ptr_q + (ADDR_W+1)'(1);
        if (push)       upd_cnt_q <= upd_cnt_q + 32'd1;
        if (hit_gather) vis_cnt_q <= vis_cnt_q + 32'd1;
      end
      if (accept) begin
        word_q <= in_word;
        mode_q <= mode;
        last_q <= in_last;
        slot_q <= '0;
      end else if (issue) begin
        slot_q <= slot_q + SlotW'(1);
      end
      s1_valid_q  <= issue && slot_act;
      s1_gather_q <= mode_q == ModeGather;
      s1_addr_q   <= src[ADDR_W-1:0];
      s1_dst_q    <= cur_slot[63:32];
      s1_level_q  <= rd_level;
      if (push) fifo_wr_q <= fifo_wr_q + FifoAw'(1);
      if (pop)  fifo_rd_q <= fifo_rd_q + FifoAw'(1);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + (FifoAw+1)'(1);
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - (FifoAw+1)'(1);
    end
  end

endmodule

// File: tb/tb_bfs_lane_param.sv
// Directed bench for bfs_lane_param: a partition-level BFS model predicts the update stream
// and counters; a negedge scoreboard checks every valid output against it.
module tb_bfs_lane_param;
  localparam int ADDR_W = 4;
  localparam int SLOTS  = 8;
  localparam int DEPTH  = 16;
  localparam logic [31:0] PAD = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic [7:0]   current_level;
  logic [31:0]  root_vertex;
  logic [511:0] in_word;
  logic         in_valid, in_last, in_ready;
  logic [31:0]  out_word;
  logic         out_valid, out_ready;
  logic [31:0]  update_count, visit_count;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  int          lvl [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] m_upd, m_vis;
  logic [63:0] slots [SLOTS];

  bfs_lane_param #(
    .ADDR_W(4), .SLOTS(8), .PARTITION_ID(0), .LEVEL_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .current_level(current_level),
    .root_vertex(root_vertex), .in_word(in_word), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .update_count(update_count), .visit_count(visit_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard: every valid head must be the oldest predicted update.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_out: got %0h, expected no output", out_word);
      end else begin
        check("out_word", out_word, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic bit is_local(input logic [31:0] v);
    return (v != PAD) && (v[31:ADDR_W] == '0);
  endfunction

  task automatic model_word(input logic [1:0] m);
    for (int k = 0; k < SLOTS; k++) begin
      logic [31:0] s, d;
      int a;
      s = slots[k][31:0];
      d = slots[k][63:32];
      a = int'(s[ADDR_W-1:0]);
      if (is_local(s)) begin
        if (m == 2'd1 && lvl[a] == int'(current_level)) begin
          exp_q.push_back(d);
          m_upd++;
        end else if (m == 2'd2 && lvl[a] == 255) begin
          lvl[a] = (int'(current_level) + 1) % 256;
          m_vis++;
        end
      end
    end
  endtask

  task automatic set_pad();
    for (int k = 0; k < SLOTS; k++) slots[k] = {32'd0, PAD};
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [1:0] m, input logic lastf);
    bit ok = 0;
    for (int k = 0; k < SLOTS; k++) in_word[64*k +: 64] = slots[k];
    mode = m;
    in_last = lastf;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0, expected word accepted");
    end else begin
      model_word(m);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [31:0] root);
    int k = 0;
    bit seen = 0;
    root_vertex = root;
    mode = 2'd3;
    @(posedge clk);
    #1 mode = 2'd0;
    while (!seen && k < 40) begin
      k++;
      @(negedge clk);
      if (done) seen = 1;
    end
    check("init_done_latency", 32'(k), 32'(DEPTH + 1));
    for (int i = 0; i < DEPTH; i++) lvl[i] = 255;
    if (is_local(root)) lvl[root[ADDR_W-1:0]] = 0;
    m_upd = 0;
    m_vis = 0;
    check("init_update_count", update_count, m_upd);
    check("init_visit_count", visit_count, m_vis);
    @(posedge clk);
    #1;
  endtask

  task automatic scatter_root_test();
    set_pad();
    slots[0] = {32'd20, 32'd3};
    current_level = 8'd0;
    send(2'd1, 1'b1);
    @(negedge clk) check("lat_t1_valid", 32'(out_valid), 32'd0);
    @(negedge clk) check("lat_t2_valid", 32'(out_valid), 32'd0);
    @(negedge clk) check("lat_t3_valid", 32'(out_valid), 32'd1);
    check("lat_t3_word", out_word, 32'd20);
    wait_done("t1_done");
    check("t1_update_count", update_count, m_upd);
    check("t1_update_lit", update_count, 32'd1);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mode = 2'd1;
    current_level = '0;
    root_vertex = '0;
    in_word = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_update_count", update_count, 32'd0);
    check("rst_visit_count", visit_count, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk) check("idle_ready_scatter", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 mode = 2'd0;
    @(negedge clk) check("idle_ready_mode0", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;

    do_init(32'd3);
    scatter_root_test();

    // Gather with a repeated vertex, then read the new levels back through a scatter.
    set_pad();
    slots[0] = {32'd0, 32'd5};
    slots[1] = {32'd0, 32'd5};
    slots[2] = {32'd0, 32'd7};
    current_level = 8'd0;
    send(2'd2, 1'b1);
    wait_done("gather_done");
    check("gather_visit", visit_count, m_vis);
    check("gather_visit_lit", visit_count, 32'd2);
    set_pad();
    slots[0] = {32'd50, 32'd5};
    slots[1] = {32'd70, 32'd7};
    slots[2] = {32'd30, 32'd3};
    slots[3] = {32'd60, 32'd6};
    current_level = 8'd1;
    send(2'd1, 1'b1);
    wait_done("readback_done");
    check("readback_update", update_count, m_upd);
    check("readback_update_lit", update_count, 32'd3);

    // Eight hits against a blocked consumer.
    out_ready = 1'b0;
    current_level = 8'd0;
    for (int k = 0; k < SLOTS; k++) slots[k] = {32'(100 + k), 32'd3};
    send(2'd1, 1'b1);
    repeat (20) @(negedge clk);
    check("stall_update_lit", update_count, 32'd7);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_head", out_word, 32'd100);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done("stall_done");
    check("stall_update", update_count, m_upd);
    check("stall_update_final", update_count, 32'd11);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Non-local aliases of live vertices and padding must not act.
    set_pad();
    slots[0] = {32'd55, 32'h103};
    slots[1] = {32'd56, 32'h13};
    current_level = 8'd0;
    send(2'd1, 1'b1);
    wait_done("nonlocal_done");
    set_pad();
    current_level = 8'hFF;
    send(2'd1, 1'b1);
    wait_done("pad_scatter_done");
    check("nonlocal_update", update_count, m_upd);
    set_pad();
    slots[0] = {32'd0, 32'h10A};
    current_level = 8'd3;
    send(2'd2, 1'b1);
    wait_done("pad_gather_done");
    check("nonlocal_visit", visit_count, m_vis);
    check("nonlocal_visit_lit", visit_count, 32'd2);
    check("nonlocal_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while processing with two buffered updates.
    out_ready = 1'b0;
    set_pad();
    slots[0] = {32'd200, 32'd3};
    slots[1] = {32'd201, 32'd3};
    current_level = 8'd0;
    send(2'd1, 1'b0);
    repeat (4) @(negedge clk);
    check("midproc_update", update_count, 32'd13);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk) check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_upd = 0;
    m_vis = 0;
    @(negedge clk);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    check("postrst_update", update_count, 32'd0);
    check("postrst_visit", visit_count, 32'd0);
    check("postrst_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    mode = 2'd0;
    do_init(32'd3);
    scatter_root_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
